add_rr_arbiter: RTL and testbench

//  Shares one registered WIDTH-bit adder among NREQ requesters using round-robin arbitration.

---
 rtl/add_rr_arbiter_if.sv | 27 ++
 rtl/add_rr_arbiter.sv | 96 +++++++++
 tb/tb_add_rr_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/add_rr_arbiter_if.sv
// Handshake bundle for add_rr_arbiter: per-requester operand channels
// plus the single result channel. slave = arbiter side, master = env side.
interface add_rr_arbiter_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int TAGW  = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_sum;
  logic                  out_carry;
  logic [TAGW-1:0]       out_tag;

  modport slave (
    input  req_valid, req_a, req_b, out_ready,
    output req_ready, out_valid, out_sum, out_carry, out_tag
  );

  modport master (
    output req_valid, req_a, req_b, out_ready,
    input  req_ready, out_valid, out_sum, out_carry, out_tag
  );
endinterface

// File: rtl/add_rr_arbiter.sv
// Round-robin shared registered adder. Ports: clk, reset (async high),
// io (slave): req_valid/ready/a/b in, out_valid/ready/sum/carry/tag out.
module add_rr_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int SATURATE = 0,
  parameter int TAGW     = 2
) (
  input logic            clk,
  input logic            reset,
  add_rr_arbiter_if.slave io
);

  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  logic [TAGW-1:0]  ptr;
  logic [TAGW-1:0]  ptr_nxt;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_sum_q;
  logic             out_carry_q;
  logic [TAGW-1:0]  out_tag_q;

  logic             slot_free;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  mask;
  logic [NREQ-1:0]  hi;
  logic [NREQ-1:0]  gnt;
  logic [TAGW-1:0]  gnt_idx;
  logic             xfer;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH:0]   sum_full;

  assign slot_free = !out_valid_q || io.out_ready;
  assign req = (slot_free && !reset) ? io.req_valid : '0;

  // Bits at or above ptr form the first search window; if none of
  // them request, the lowest requester overall wins (the wrap).
  always_comb begin
    mask = '0;
    for (int i = 0; i < NREQ; i++) begin
      mask[i] = (i >= int'(ptr));
    end
  end

  assign hi  = req & mask;
  assign gnt = (|hi) ? (hi & (~hi + ONE))
                     : (req & (~req + ONE));
  assign xfer = |gnt;

  always_comb begin
    gnt_idx = '0;
    sel_a   = '0;
    sel_b   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_idx = TAGW'(i);
        sel_a   = io.req_a[i*WIDTH +: WIDTH];
        sel_b   = io.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  assign sum_full = {1'b0, sel_a} + {1'b0, sel_b};

  assign ptr_nxt = (gnt_idx == TAGW'(NREQ-1)) ? '0
                                              : gnt_idx + TAGW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr         <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_carry_q <= 1'b0;
      out_tag_q   <= '0;
    end else if (xfer) begin
      ptr         <= ptr_nxt;
      out_valid_q <= 1'b1;
      out_carry_q <= sum_full[WIDTH];
      out_tag_q   <= gnt_idx;
      if (SATURATE != 0 && sum_full[WIDTH])
        out_sum_q <= '1;
      else
        out_sum_q <= sum_full[WIDTH-1:0];
    end else if (out_valid_q && io.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign io.req_ready = gnt;
  assign io.out_valid = out_valid_q;
  assign io.out_sum   = out_sum_q;
  assign io.out_carry = out_carry_q;
  assign io.out_tag   = out_tag_q;

endmodule

// File: tb/tb_add_rr_arbiter.sv
// Directed bench for add_rr_arbiter: wrap and saturate instances share
// stimulus; each task checks its scenario inline.
module tb_add_rr_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  add_rr_arbiter_if #(.NREQ(4), .WIDTH(8), .TAGW(2)) if0 ();
  add_rr_arbiter_if #(.NREQ(4), .WIDTH(8), .TAGW(2)) if1 ();

  assign if1.req_valid = if0.req_valid;
  assign if1.req_a     = if0.req_a;
  assign if1.req_b     = if0.req_b;
  assign if1.out_ready = if0.out_ready;

  add_rr_arbiter #(.NREQ(4), .WIDTH(8), .SATURATE(0), .TAGW(2)) u0 (
    .clk(clk), .reset(reset), .io(if0)
  );
  add_rr_arbiter #(.NREQ(4), .WIDTH(8), .SATURATE(1), .TAGW(2)) u1 (
    .clk(clk), .reset(reset), .io(if1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [7:0] a,
                        input logic [7:0] b);
    if0.req_a[i*8 +: 8] = a;
    if0.req_b[i*8 +: 8] = b;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    if0.req_valid = '0;
    tick();
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    if0.req_valid = 4'b1111;
    #1;
    vectors++;
    if (if0.req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL rst_ready: got %b expected 0000", if0.req_ready);
    end
    vectors++;
    if ({if0.out_valid, if0.out_sum, if0.out_carry, if0.out_tag} !== 12'h000) begin
      miscompares++;
      $display("FAIL rst_out: got v=%0d s=%0d c=%0d t=%0d expected all 0",
               if0.out_valid, if0.out_sum, if0.out_carry, if0.out_tag);
    end
    do_reset();
  endtask

  task automatic test_single();
    set_op(0, 8'd3, 8'd4);
    if0.req_valid = 4'b0001;
    #1;
    vectors++;
    if (if0.req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL single_ready: got %b expected 0001", if0.req_ready);
    end
    tick();
    if0.req_valid = '0;
    vectors++;
    if (if0.out_valid !== 1'b1 || if0.out_sum !== 8'd7 ||
        if0.out_carry !== 1'b0 || if0.out_tag !== 2'd0) begin
      miscompares++;
      $display("FAIL single_out: got v=%0d s=%0d c=%0d t=%0d expected 1 7 0 0",
               if0.out_valid, if0.out_sum, if0.out_carry, if0.out_tag);
    end
    tick();
    vectors++;
    if (if0.out_valid !== 1'b0 || if0.out_sum !== 8'd7) begin
      miscompares++;
      $display("FAIL drain: got v=%0d s=%0d expected 0 7",
               if0.out_valid, if0.out_sum);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int i = 0; i < 4; i++) set_op(i, 8'(10 + i), 8'd20);
    if0.req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      tick();
      vectors++;
      if (if0.out_valid !== 1'b1 || if0.out_tag !== 2'(k % 4) ||
          if0.out_sum !== 8'(30 + k % 4)) begin
        miscompares++;
        $display("FAIL rr_%0d: got v=%0d t=%0d s=%0d expected 1 %0d %0d",
                 k, if0.out_valid, if0.out_tag, if0.out_sum, k % 4, 30 + k % 4);
      end
    end
    if0.req_valid = '0;
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    set_op(1, 8'd200, 8'd100);
    if0.req_valid = 4'b0010;
    tick();
    if0.req_valid = '0;
    vectors++;
    if (if0.out_sum !== 8'd44 || if0.out_carry !== 1'b1 ||
        if0.out_tag !== 2'd1) begin
      miscompares++;
      $display("FAIL wrap: got s=%0d c=%0d t=%0d expected 44 1 1",
               if0.out_sum, if0.out_carry, if0.out_tag);
    end
    vectors++;
    if (if1.out_sum !== 8'd255 || if1.out_carry !== 1'b1 ||
        if1.out_tag !== 2'd1) begin
      miscompares++;
      $display("FAIL sat: got s=%0d c=%0d t=%0d expected 255 1 1",
               if1.out_sum, if1.out_carry, if1.out_tag);
    end
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_op(0, 8'd5, 8'd6);
    set_op(1, 8'd1, 8'd2);
    set_op(2, 8'd7, 8'd8);
    if0.req_valid = 4'b0001;
    tick();
    if0.out_ready = 1'b0;
    if0.req_valid = 4'b0110;
    for (int k = 0; k < 3; k++) begin
      #1;
      vectors++;
      if (if0.req_ready !== 4'b0000 || if0.out_valid !== 1'b1 ||
          if0.out_sum !== 8'd11 || if0.out_tag !== 2'd0) begin
        miscompares++;
        $display("FAIL bp_%0d: got r=%b v=%0d s=%0d t=%0d expected 0000 1 11 0",
                 k, if0.req_ready, if0.out_valid, if0.out_sum, if0.out_tag);
      end
      tick();
    end
    if0.out_ready = 1'b1;
    #1;
    vectors++;
    if (if0.req_ready !== 4'b0010) begin
      miscompares++;
      $display("FAIL bp_release: got %b expected 0010", if0.req_ready);
    end
    tick();
    if0.req_valid = 4'b0100;
    vectors++;
    if (if0.out_valid !== 1'b1 || if0.out_tag !== 2'd1 ||
        if0.out_sum !== 8'd3) begin
      miscompares++;
      $display("FAIL bp_tag1: got v=%0d t=%0d s=%0d expected 1 1 3",
               if0.out_valid, if0.out_tag, if0.out_sum);
    end
    tick();
    if0.req_valid = '0;
    vectors++;
    if (if0.out_valid !== 1'b1 || if0.out_tag !== 2'd2 ||
        if0.out_sum !== 8'd15) begin
      miscompares++;
      $display("FAIL bp_tag2: got v=%0d t=%0d s=%0d expected 1 2 15",
               if0.out_valid, if0.out_tag, if0.out_sum);
    end
    tick();
  endtask

  task automatic test_wrap();
    if0.req_valid = 4'b1000;
    tick();
    vectors++;
    if (if0.out_tag !== 2'd3) begin
      miscompares++;
      $display("FAIL wrap_g3: got t=%0d expected 3", if0.out_tag);
    end
    if0.req_valid = 4'b1001;
    #1;
    vectors++;
    if (if0.req_ready !== 4'b0001) begin
      miscompares++;
      $display("FAIL wrap_first: got %b expected 0001", if0.req_ready);
    end
    tick();
    if0.req_valid = 4'b1000;
    vectors++;
    if (if0.out_tag !== 2'd0) begin
      miscompares++;
      $display("FAIL wrap_t0: got t=%0d expected 0", if0.out_tag);
    end
    tick();
    if0.req_valid = '0;
    vectors++;
    if (if0.out_tag !== 2'd3 || if0.out_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL wrap_t3: got t=%0d v=%0d expected 3 1",
               if0.out_tag, if0.out_valid);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    if0.req_valid = 4'b1111;
    tick();
    vectors++;
    if (if0.out_valid !== 1'b1 || if0.out_tag !== 2'd0) begin
      miscompares++;
      $display("FAIL mid_pre: got v=%0d t=%0d expected 1 0",
               if0.out_valid, if0.out_tag);
    end
    reset = 1'b1;
    #1;
    vectors++;
    if (if0.out_valid !== 1'b0 || if0.req_ready !== 4'b0000) begin
      miscompares++;
      $display("FAIL mid_rst: got v=%0d r=%b expected 0 0000",
               if0.out_valid, if0.req_ready);
    end
    tick();
    #2;
    reset = 1'b0;
    set_op(2, 8'd9, 8'd9);
    if0.req_valid = 4'b0100;
    #1;
    vectors++;
    if (if0.req_ready !== 4'b0100) begin
      miscompares++;
      $display("FAIL mid_ready: got %b expected 0100", if0.req_ready);
    end
    tick();
    if0.req_valid = '0;
    vectors++;
    if (if0.out_valid !== 1'b1 || if0.out_tag !== 2'd2 ||
        if0.out_sum !== 8'd18) begin
      miscompares++;
      $display("FAIL mid_after: got v=%0d t=%0d s=%0d expected 1 2 18",
               if0.out_valid, if0.out_tag, if0.out_sum);
    end
  endtask

  initial begin
    if0.req_valid = '0;
    if0.req_a     = '0;
    if0.req_b     = '0;
    if0.out_ready = 1'b1;
    tick();
    test_reset();
    test_single();
    test_round_robin();
    test_saturate();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
